// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit with architectural HI/LO registers, placed
// next to the ALU in the EXE stage. MULT/MULTU/DIV/DIVU take one radix-2 step
// per cycle (shift-add multiply, restoring divide) followed by a sign-fix
// cycle. MTHI/MTLO and divide-by-zero finish in one cycle. While an operation
// is in flight, busy asks the pipeline controller to stall.
//
// Handshake: start is a request that the controller holds (together with op,
// a and b) until it is accepted. It is accepted only on a rising edge where
// the FSM is in IDLE and flush is low; starts seen in ITER, FIX or DONE are
// dropped, so the controller keeps the instruction held while busy/done. done
// is a single-cycle completion pulse with no backpressure, and hi/lo already
// hold the result in that cycle.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high reset
//   start        operation request (sampled only in IDLE)
//   op[2:0]      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b         operands (a is also the MTHI/MTLO data)
//   flush        abort the in-flight operation
//   busy         high in ITER and FIX
//   done         one-cycle completion pulse
//   div_by_zero  qualified by done; divide with b == 0
//   hi, lo       architectural HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // state_q is the FSM state observable by checkers
    state_t state_q;
    state_t state_next;

    logic [2*WIDTH-1:0] acc;       // {remainder, quotient} or running product
    logic [WIDTH-1:0]   opnd;      // divisor magnitude or multiplicand magnitude
    logic [CW-1:0]      count;
    logic               div_q;
    logic               neg_res_q; // negate product / quotient
    logic               neg_rem_q; // negate remainder
    logic               dbz_q;

    // ---------------- request decode (meaningful only in IDLE) ----------------
    logic             signed_op;
    logic             b_zero;
    logic             req;
    logic             go_iter;
    logic             go_dz;
    logic             go_mthi;
    logic             go_mtlo;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        signed_op = ~op[0];
        b_zero    = (b == '0);
        req       = (state_q == IDLE) && start && !flush;
        go_iter   = req && !op[2] && !(op[1] && b_zero);
        go_dz     = req && !op[2] && op[1] && b_zero;
        go_mthi   = req && (op == OP_MTHI);
        go_mtlo   = req && (op == OP_MTLO);
        abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
        abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    end

    // ---------------- one iteration step ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier LSB is set, keep the carry, then shift right by one.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // Restoring divide: bring in the next dividend bit, trial subtract;
        // a clear borrow bit means the subtraction stands and q bit is 1.
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd};
        if (!rem_diff[WIDTH]) begin
            div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod_fix = neg_res_q ? -acc : acc;
        quo_fix  = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_hi   = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: begin
                if (go_iter) begin
                    state_next = ITER;
                end else if (go_dz || go_mthi || go_mtlo) begin
                    state_next = DONE;
                end
            end
            ITER: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (count == LAST) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = flush ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy        = (state_q == ITER) || (state_q == FIX);
        done        = (state_q == DONE);
        div_by_zero = (state_q == DONE) && dbz_q;
    end

    // ---------------- datapath and HI/LO ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            hi        <= HILO_RESET;
            lo        <= HILO_RESET;
            acc       <= '0;
            opnd      <= '0;
            count     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            dbz_q <= go_dz;
            case (state_q)
                IDLE: begin
                    if (go_iter) begin
                        div_q     <= op[1];
                        neg_res_q <= signed_op && (a[WIDTH-1] != b[WIDTH-1]);
                        neg_rem_q <= signed_op && a[WIDTH-1];
                        count     <= '0;
                        if (op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, abs_a};
                            opnd <= abs_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, abs_b};
                            opnd <= abs_a;
                        end
                    end
                    if (go_mthi) hi <= a;
                    if (go_mtlo) lo <= a;
                end
                ITER: begin
                    acc   <= div_q ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                FIX: begin
                    // hi and lo update together on the FIX->DONE edge only
                    if (!flush) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int W8 = 8;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // 32-bit instance
    logic         start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    // 8-bit instance
    logic          s8_start, s8_flush;
    logic [2:0]    s8_op;
    logic [W8-1:0] s8_a, s8_b;
    logic          s8_busy, s8_done, s8_dz;
    logic [W8-1:0] s8_hi, s8_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(W8)) dut8 (
        .clock(clock), .reset(reset), .start(s8_start), .op(s8_op), .a(s8_a),
        .b(s8_b), .flush(s8_flush), .busy(s8_busy), .done(s8_done),
        .div_by_zero(s8_dz), .hi(s8_hi), .lo(s8_lo)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
    endtask

    // Called at a negedge right after a request was driven. Counts negedges
    // until done (bounded); lat stays 0 if done never arrives.
    task automatic wait_done(output int lat, output int busy_n,
                             output logic [W-1:0] got_hi, output logic [W-1:0] got_lo,
                             output logic got_dz);
        lat = 0; busy_n = 0; got_hi = '0; got_lo = '0; got_dz = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                lat    = i;
                got_hi = hi;
                got_lo = lo;
                got_dz = div_by_zero;
                break;
            end
        end
    endtask

    task automatic run8(input logic [2:0] o, input logic [W8-1:0] va, input logic [W8-1:0] vb,
                        output int lat, output int busy_n,
                        output logic [W8-1:0] got_hi, output logic [W8-1:0] got_lo);
        s8_start = 1'b1; s8_op = o; s8_a = va; s8_b = vb;
        lat = 0; busy_n = 0; got_hi = '0; got_lo = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            s8_start = 1'b0;
            if (s8_busy) busy_n++;
            if (s8_done) begin
                lat = i; got_hi = s8_hi; got_lo = s8_lo;
                break;
            end
        end
        @(negedge clock);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dz;
        int           exp_lat;
        int           exp_busy;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int lat, busy_n, dcnt;
        logic [W-1:0] g_hi, g_lo;
        logic g_dz;
        logic [W8-1:0] h8, l8;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 33};
        vecs[2]  = '{OP_MULT,  32'd5,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b0, 34, 33};
        vecs[3]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 33};
        vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33};
        vecs[5]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 34, 33};
        vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34, 33};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34, 33};
        vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 34, 33};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 34, 33};
        vecs[10] = '{OP_DIVU,  32'd3,        32'd5,        32'd3,        32'd0,        1'b0, 34, 33};
        vecs[11] = '{OP_MTHI,  32'h1234,     32'd0,        32'h1234,     32'd0,        1'b0, 1,  0};
        vecs[12] = '{OP_MTLO,  32'h5678,     32'd0,        32'h1234,     32'h5678,     1'b0, 1,  0};
        vecs[13] = '{OP_DIV,   32'd5,        32'd0,        32'h1234,     32'h5678,     1'b1, 1,  0};
        vecs[14] = '{OP_DIVU,  32'd9,        32'd0,        32'h1234,     32'h5678,     1'b1, 1,  0};
        vecs[15] = '{OP_MULTU, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 34, 33};

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        s8_start = 1'b0; s8_flush = 1'b0; s8_op = '0; s8_a = '0; s8_b = '0;

        // ---- reset values ----
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // ---- table-driven vectors ----
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(vecs[i].exp_hi);
            exp_q.push_back(vecs[i].exp_lo);
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, busy_n, g_hi, g_lo, g_dz);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy", i), 64'(busy_n), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_dz", i), 64'(g_dz), 64'(vecs[i].exp_dz));
            check($sformatf("vec%0d_hi", i), 64'(g_hi), 64'(exp_q.pop_front()));
            check($sformatf("vec%0d_lo", i), 64'(g_lo), 64'(exp_q.pop_front()));
            @(negedge clock);
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // ---- back-to-back: start in DONE is ignored ----
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, busy_n, g_hi, g_lo, g_dz);
        check("b2b_first_hi", 64'(g_hi), 64'hFFFFFFFE);
        check("b2b_first_lo", 64'(g_lo), 64'h00000001);
        start_op(OP_MULTU, 32'd2, 32'd9);       // driven in the DONE cycle
        @(negedge clock);
        check("b2b_ignored_busy", 64'(busy), 64'd0);
        check("b2b_ignored_done", 64'(done), 64'd0);
        wait_done(lat, busy_n, g_hi, g_lo, g_dz);  // start still held -> accepted now
        check("b2b_second_lat", 64'(lat), 64'd34);
        check("b2b_second_hi", 64'(g_hi), 64'd0);
        check("b2b_second_lo", 64'(g_lo), 64'd18);
        @(negedge clock);

        // ---- flush mid-operation, start during busy ignored ----
        start_op(OP_MULTU, 32'd6, 32'd7);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (i == 3) start_op(OP_MTLO, 32'hDEAD, 32'd0);
            if (i == 4) check("busy_start_ignored", 64'(busy), 64'd1);
            if (i == 10) flush = 1'b1;
        end
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        check("flush_no_done", 64'(dcnt), 64'd0);
        check("flush_hi", 64'(hi), 64'd0);
        check("flush_lo", 64'(lo), 64'd18);
        start_op(OP_MULTU, 32'd6, 32'd7);
        wait_done(lat, busy_n, g_hi, g_lo, g_dz);
        check("post_flush_lat", 64'(lat), 64'd34);
        check("post_flush_hi", 64'(g_hi), 64'd0);
        check("post_flush_lo", 64'(g_lo), 64'd42);
        @(negedge clock);

        // ---- flush with start in IDLE suppresses it ----
        start_op(OP_MTHI, 32'h777, 32'd0);
        flush = 1'b1;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_done", 64'(done), 64'd0);
        check("idle_flush_hi", 64'(hi), 64'd0);

        // ---- undefined op is ignored ----
        start_op(3'b110, 32'd5, 32'd5);
        @(negedge clock);
        start = 1'b0;
        check("undef_done", 64'(done), 64'd0);
        check("undef_busy", 64'(busy), 64'd0);
        check("undef_lo", 64'(lo), 64'd42);

        // ---- reset mid-operation ----
        start_op(OP_DIVU, 32'd100, 32'd7);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (i == 5) reset = 1'b1;
        end
        @(negedge clock);
        reset = 1'b0;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clock);

        // ---- WIDTH = 8 instance ----
        run8(OP_DIVU, 8'd100, 8'd7, lat, busy_n, h8, l8);
        check("w8_divu_lat", 64'(lat), 64'd10);
        check("w8_divu_busy", 64'(busy_n), 64'd9);
        check("w8_divu_lo", 64'(l8), 64'd14);
        check("w8_divu_hi", 64'(h8), 64'd2);
        run8(OP_DIV, 8'h9C, 8'd7, lat, busy_n, h8, l8);
        check("w8_div_lo", 64'(l8), 64'hF2);
        check("w8_div_hi", 64'(h8), 64'hFE);
        run8(OP_MULT, 8'hF0, 8'h10, lat, busy_n, h8, l8);
        check("w8_mult_hi", 64'(h8), 64'hFF);
        check("w8_mult_lo", 64'(l8), 64'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
